// File: rtl/data_port_pkg.sv
// Shared constants for the data-side bus responder.
// No ports: address map, status bit positions and a status word helper.
package data_port_pkg;

    localparam logic [13:0] ADDR_LED    = 14'h2000;
    localparam logic [13:0] ADDR_CYCLES = 14'h2001;
    localparam logic [13:0] ADDR_TXDATA = 14'h2002;
    localparam logic [13:0] ADDR_TXSTAT = 14'h2003;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    // The count field is 4 bits wide; the mask keeps wider counts
    // from spilling into bits above 11.
    function automatic logic [31:0] status_word(
        input logic        full,
        input logic        empty,
        input logic        ovf,
        input logic [31:0] cnt
    );
        logic [31:0] w;
        w = (cnt << ST_CNT_LSB) & 32'h0000_0F00;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        w[ST_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/data_port_if.sv
// CPU data bus: word address, write data, write strobe and read data.
// master = CPU side, slave = data_port side.
interface data_port_if;

    logic [13:0] dataAddress;
    logic [31:0] dataOut;
    logic        dataWrEn;
    logic [31:0] dataIn;

    modport master (
        output dataAddress,
        output dataOut,
        output dataWrEn,
        input  dataIn
    );

    modport slave (
        input  dataAddress,
        input  dataOut,
        input  dataWrEn,
        output dataIn
    );

endinterface

// File: rtl/data_port_tx_fifo.sv
// Byte transmit FIFO: circular buffer with pointers, count and sticky overflow.
// Ports: push/din/full, pop/dout/empty, count, overflow, clr_ovf.
module tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    output logic                        full,
    input  logic                        pop,
    output logic [WIDTH-1:0]            dout,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    input  logic                        clr_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Full is judged on the pre-edge count, so a push at full is
    // dropped even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_port.sv
// Data-bus responder: async-read RAM, LED register, cycle counter, TX FIFO.
// Ports: clk, nRst, bus (slave), leds, txData/txValid/txReady stream.
module data_port
    import data_port_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             nRst,
    data_port_if.slave       bus,
    output logic [7:0]       leds,
    output logic [7:0]       txData,
    output logic             txValid,
    input  logic             txReady
);

    logic [31:0]               ram [2**RAM_AW];
    logic [31:0]               cycles;
    logic [31:0]               rdata;
    logic [31:0]               stat;
    logic [RAM_AW-1:0]         ram_idx;
    logic                      is_ram;
    logic                      sel_led;
    logic                      sel_cyc;
    logic                      sel_txd;
    logic                      sel_sts;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_ovf;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    assign is_ram  = !bus.dataAddress[13];
    assign ram_idx = bus.dataAddress[RAM_AW-1:0];
    assign sel_led = (bus.dataAddress == ADDR_LED);
    assign sel_cyc = (bus.dataAddress == ADDR_CYCLES);
    assign sel_txd = (bus.dataAddress == ADDR_TXDATA);
    assign sel_sts = (bus.dataAddress == ADDR_TXSTAT);

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk      (clk),
        .nRst     (nRst),
        .push     (bus.dataWrEn && sel_txd),
        .din      (bus.dataOut[7:0]),
        .full     (fifo_full),
        .pop      (txReady),
        .dout     (txData),
        .empty    (fifo_empty),
        .count    (fifo_cnt),
        .overflow (fifo_ovf),
        .clr_ovf  (bus.dataWrEn && sel_sts)
    );

    assign txValid = !fifo_empty;

    // RAM is not reset; writes are gated so none land while nRst is low.
    always_ff @(posedge clk) begin
        if (bus.dataWrEn && nRst && is_ram) begin
            ram[ram_idx] <= bus.dataOut;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            leds   <= '0;
            cycles <= '0;
        end else begin
            if (bus.dataWrEn && sel_cyc) begin
                cycles <= bus.dataOut;
            end else begin
                cycles <= cycles + 32'd1;
            end
            if (bus.dataWrEn && sel_led) begin
                leds <= bus.dataOut[7:0];
            end
        end
    end

    assign stat = status_word(fifo_full, fifo_empty, fifo_ovf,
                              32'(fifo_cnt));

    // Read path must stay combinational: the CPU samples it one edge
    // after driving the address.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            is_ram:  rdata = ram[ram_idx];
            sel_led: rdata = {24'd0, leds};
            sel_cyc: rdata = cycles;
            sel_sts: rdata = stat;
            default: rdata = '0;
        endcase
    end

    assign bus.dataIn = rdata;

endmodule

// File: tb/tb_data_port.sv
// Self-checking bench for data_port with a queue scoreboard for TX bytes.
// Drives on negedge, samples 1 ns later.
module tb_data_port;

    logic       clk;
    logic       nRst;
    logic [7:0] leds;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;

    int errors;
    int checks;
    logic [7:0] sb [$];

    data_port_if bus ();

    data_port #(
        .RAM_AW     (10),
        .FIFO_DEPTH (8)
    ) dut (
        .clk     (clk),
        .nRst    (nRst),
        .bus     (bus),
        .leds    (leds),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.dataAddress = a;
        bus.dataOut     = d;
        bus.dataWrEn    = 1'b1;
        @(posedge clk);
        #1;
        bus.dataWrEn    = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.dataAddress = a;
        #1;
        d = bus.dataIn;
    endtask

    task automatic push_byte(input logic [7:0] b);
        if (sb.size() < 8) sb.push_back(b);
        wr(14'h2002, {24'hABCDEF, b});
    endtask

    task automatic drain(input string name);
        int budget;
        logic [7:0] exp;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(negedge clk);
            txReady = 1'b1;
            #1;
            checks++;
            if (txValid !== 1'b1) begin
                errors++;
                $display("FAIL %s txValid got %b want 1", name, txValid);
            end else begin
                exp = sb.pop_front();
                if (txData !== exp) begin
                    errors++;
                    $display("FAIL %s txData got %h want %h",
                             name, txData, exp);
                end
            end
            budget++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s timeout left=%0d", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
        #1;
        checks++;
        if (txValid !== 1'b0) begin
            errors++;
            $display("FAIL %s txValid_end got %b want 0", name, txValid);
        end
        txReady = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] a;
        logic [31:0] b;
        nRst = 1'b0;
        repeat (2) @(negedge clk);
        bus.dataAddress = 14'h2000;
        bus.dataOut     = 32'h0000_00FF;
        bus.dataWrEn    = 1'b1;
        @(negedge clk);
        bus.dataWrEn    = 1'b0;
        bus.dataAddress = 14'h2003;
        #1;
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL rst_leds got %h want 00", leds);
        end
        checks++;
        if (txValid !== 1'b0 || txData !== 8'h00) begin
            errors++;
            $display("FAIL rst_tx got %b/%h want 0/00", txValid, txData);
        end
        checks++;
        if (bus.dataIn !== 32'h0000_0002) begin
            errors++;
            $display("FAIL rst_stat got %h want 00000002", bus.dataIn);
        end
        @(negedge clk);
        nRst = 1'b1;
        rd(14'h2001, a);
        repeat (4) @(negedge clk);
        rd(14'h2001, b);
        checks++;
        if (b - a !== 32'd5) begin
            errors++;
            $display("FAIL cyc_delta got %0d want 5", b - a);
        end
    endtask

    task automatic test_ram;
        logic [31:0] d;
        wr(14'h0005, 32'hDEAD_BEEF);
        rd(14'h0005, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_rd got %h want deadbeef", d);
        end
        rd(14'h0405, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_alias got %h want deadbeef", d);
        end
        wr(14'h0006, 32'h0123_4567);
        rd(14'h0005, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_keep got %h want deadbeef", d);
        end
    endtask

    task automatic test_led;
        logic [31:0] d;
        wr(14'h2000, 32'h1234_56A5);
        checks++;
        if (leds !== 8'hA5) begin
            errors++;
            $display("FAIL leds got %h want a5", leds);
        end
        rd(14'h2000, d);
        checks++;
        if (d !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL led_rd got %h want 000000a5", d);
        end
        rd(14'h2ABC, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped got %h want 0", d);
        end
        wr(14'h2ABC, 32'hFFFF_FFFF);
        rd(14'h2002, d);
        checks++;
        if (d !== 32'h0 || leds !== 8'hA5) begin
            errors++;
            $display("FAIL txd_rd got %h/%h want 0/a5", d, leds);
        end
    endtask

    task automatic test_fifo_overflow;
        logic [31:0] d;
        txReady = 1'b0;
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        rd(14'h2003, d);
        checks++;
        if (d !== 32'h0000_0805) begin
            errors++;
            $display("FAIL fill_stat got %h want 00000805", d);
        end
        checks++;
        if (txData !== 8'h01) begin
            errors++;
            $display("FAIL hold_head got %h want 01", txData);
        end
        drain("drain1");
        rd(14'h2003, d);
        checks++;
        if (d !== 32'h0000_0006) begin
            errors++;
            $display("FAIL empty_stat got %h want 00000006", d);
        end
        wr(14'h2003, 32'h0);
        rd(14'h2003, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++;
            $display("FAIL clr_stat got %h want 00000002", d);
        end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] d;
        logic [7:0]  exp;
        txReady = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        @(negedge clk);
        bus.dataAddress = 14'h2002;
        bus.dataOut     = 32'h0000_0055;
        bus.dataWrEn    = 1'b1;
        txReady         = 1'b1;
        #1;
        exp = sb.pop_front();
        checks++;
        if (txValid !== 1'b1 || txData !== exp) begin
            errors++;
            $display("FAIL pp_head got %b/%h want 1/%h", txValid, txData, exp);
        end
        @(posedge clk);
        #1;
        bus.dataWrEn = 1'b0;
        txReady      = 1'b0;
        rd(14'h2003, d);
        checks++;
        if (d !== 32'h0000_0704) begin
            errors++;
            $display("FAIL pp_stat got %h want 00000704", d);
        end
        wr(14'h2003, 32'hFFFF_FFFF);
        rd(14'h2003, d);
        checks++;
        if (d !== 32'h0000_0700) begin
            errors++;
            $display("FAIL pp_clr got %h want 00000700", d);
        end
        drain("drain2");
    endtask

    task automatic test_counter_wrap;
        logic [31:0] d;
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFFE;
        exp[1] = 32'hFFFF_FFFF;
        exp[2] = 32'h0000_0000;
        wr(14'h2001, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            rd(14'h2001, d);
            checks++;
            if (d !== exp[i]) begin
                errors++;
                $display("FAIL cyc_wrap%0d got %h want %h", i, d, exp[i]);
            end
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        nRst            = 1'b0;
        txReady         = 1'b0;
        bus.dataAddress = '0;
        bus.dataOut     = '0;
        bus.dataWrEn    = 1'b0;
        test_reset();
        test_ram();
        test_led();
        test_fifo_overflow();
        test_full_push_pop();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
